// File: rtl/div5_frame_tx.sv
// Serial frame transmitter: shifts a WIDTH-bit word out MSB-first, then a
// 3-bit pad that makes every frame, read as an unsigned number, divisible by 5.
module div5_frame_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             serial_o,
   output logic             serial_valid_o,
   output logic             last_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   // Handshake: a word moves on a rising edge where valid_i && ready_o;
   // valid_i may drop at any time and data_i is ignored without a transfer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [2:0]       pad_q;
   logic [2:0]       rem_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       pad_cnt_q;

   logic [3:0] rem_dbl;
   logic [2:0] rem_next;
   logic [3:0] pad_dbl;
   logic [2:0] pad_next;
   logic       transfer;

   // Running remainder of the frame so far, and the pad that cancels it.
   always_comb begin
      rem_dbl  = {rem_q, 1'b0} + {3'b000, shift_q[WIDTH-1]};
      rem_next = (rem_dbl >= 4'd5) ? 3'(rem_dbl - 4'd5) : rem_dbl[2:0];
      pad_dbl  = {rem_next, 1'b0};
      pad_next = (pad_dbl >= 4'd5) ? 3'(pad_dbl - 4'd5) : pad_dbl[2:0];
   end

   always_comb begin
      serial_o       = 1'b0;
      serial_valid_o = 1'b0;
      last_o         = 1'b0;
      case (state_q)
         DATA: begin
            serial_o       = shift_q[WIDTH-1];
            serial_valid_o = 1'b1;
         end
         PAD: begin
            serial_o       = pad_q[2];
            serial_valid_o = 1'b1;
            last_o         = (pad_cnt_q == 2'd2);
         end
         default: ;
      endcase
   end

   assign ready_o  = (state_q == IDLE) || last_o;
   assign transfer = valid_i && ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         pad_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         pad_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (transfer) begin
                  state_q <= DATA;
                  shift_q <= data_i;
                  rem_q   <= '0;
                  cnt_q   <= CNT_LOAD;
               end
            end
            DATA: begin
               rem_q   <= rem_next;
               shift_q <= shift_q << 1;
               cnt_q   <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q   <= PAD;
                  pad_q     <= pad_next;
                  pad_cnt_q <= '0;
               end
            end
            PAD: begin
               pad_q     <= pad_q << 1;
               pad_cnt_q <= pad_cnt_q + 2'd1;
               if (pad_cnt_q == 2'd2) begin
                  // Back-to-back: a transfer here starts the next frame with no gap.
                  if (transfer) begin
                     state_q <= DATA;
                     shift_q <= data_i;
                     rem_q   <= '0;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/div5_frame_tx.md
# div5_frame_tx

Serial frame transmitter for the mod-5 serial link. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line. It then appends a 3-bit pad so that each transmitted frame, read as an unsigned binary number, is divisible by 5. A downstream MSB-first divisible-by-5 checker that samples every cycle therefore reports divisible at every frame boundary, so the block acts as the stimulus and encoder end of that link.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- data_i  input  WIDTH  parallel word to transmit, sampled on the handshake.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- serial_o  output  1  serial bit stream, MSB first.
- serial_valid_o  output  1  serial_o carries a frame bit (data or pad).
- last_o  output  1  current bit is the final pad bit of the frame.

## Operation
- Transfer occurs on a rising edge with valid_i && ready_o. No transfer takes place without ready_o, and data_i is ignored when no transfer occurs. valid_i may deassert at any time.
- State machine states:
  - IDLE: ready_o=1, serial_o=0, serial_valid_o=0, last_o=0.
  - DATA: WIDTH cycles. serial_o = shift-register MSB, serial_valid_o=1.
  - PAD: 3 cycles. serial_o = pad-register MSB, serial_valid_o=1. last_o=1 on the 3rd pad cycle only.
- Transitions:
  - IDLE -> DATA on transfer. On this edge, load the shift register with data_i, clear rem to 0, and load the bit counter with WIDTH-1.
  - DATA: on each edge, rem <= (2*rem + serial_o) mod 5, shift left by 1, and decrement the counter. On the edge where counter==0, go to PAD and load the 3-bit pad register with s = (2*rem_next) mod 5, where rem_next is the updated remainder that includes the last data bit.
  - PAD: shift the pad register left each edge. On the 3rd pad edge, go to DATA if a transfer occurs on that edge, otherwise go to IDLE.
- ready_o = (state==IDLE) || (state==PAD && last_o). This allows back-to-back frames with no gap.
- Pad mapping from rem to s, with 3'bXYZ sent X first:
  - rem 0 -> s 0 (000)
  - rem 1 -> s 2 (010)
  - rem 2 -> s 4 (100)
  - rem 3 -> s 1 (001)
  - rem 4 -> s 3 (011)
- Correctness: frame value = 8*D + s ≡ 3*rem + 2*rem ≡ 0 (mod 5).
- rem is 3 bits and always in 0..4. The counter width is $clog2(WIDTH) bits, minimum 1.
- Idle line is 0. Appending zeros to a multiple of 5 keeps it a multiple of 5, so a receiver running continuously stays at remainder 0 between frames.
- Reset, asynchronous at any time including mid-frame: state=IDLE, shift, pad, rem and counter cleared. After reset: ready_o=1, serial_o=0, serial_valid_o=0, last_o=0. A partially sent frame is dropped and never resumed.

## Timing
- All outputs are decoded from registers only. There is no combinational path from data_i or valid_i to any output, and ready_o depends on state only.
- Latency: transfer at edge k puts the data MSB on serial_o in the cycle after edge k.
- Frame length is WIDTH+3 cycles with serial_valid_o=1 throughout. last_o is high in cycle WIDTH+3 of the frame.
- Back-to-back: a transfer on the last_o edge puts the next frame's MSB in the immediately following cycle, so serial_valid_o stays high continuously.
- Throughput: one word per WIDTH+3 cycles maximum.
- A downstream MSB-first mod-5 checker, reset together with this block, shows remainder 0 in the cycle after each last_o edge.

## Test plan
- WIDTH=8, data_i=8'd1 -> serial_o 00000001 then pad 010; frame value 10; last_o on the 11th bit; checker divisible=1 after the frame.
- data_i=8'd7 -> rem 2, pad 100, frame value 60. data_i=8'hFF -> rem 0, pad 000, frame value 2040. data_i=8'd0 -> eleven 0 bits.
- Exhaustive sweep of all 256 words, frames spaced by random idle gaps -> checker divisible=1 after every frame and stays 1 across idle cycles; serial_o=0 whenever serial_valid_o=0.
- Back-to-back with valid_i held high for 8'd3, 8'd4, 8'd9 -> ready_o pulses only in IDLE or on last_o cycles; serial_valid_o stays high for 33 consecutive cycles; pads 001, 011, 011.
- valid_i toggling while busy (DATA or PAD) -> no transfer and the current frame is unchanged. valid_i low in IDLE -> outputs stay at idle values.
- rst_n asserted during bit 4 of frame 8'hA5 -> outputs go to idle values immediately, with no clock needed. After release, 8'd1 is accepted and its frame is correct.
